ibus8_master: RTL and testbench

- Initiator side of the SoC's 8-bit internal peripheral bus. It drives `data_o`, `wr_n`, `rd_n` and the per-peripheral `en` selects consumed by register-style peripherals such as port selectors.
- Accepts single read/write requests from a CPU-side bridge and sequences setup/strobe/hold timing.
- Captures read data and returns a one-cycle acknowledge.
- Guarantees data and select are stable across the rising edge of `wr_n`, which is where peripherals latch.

---
 rtl/ibus8_master.sv | 162 ++++++++++++++++
 tb/tb_ibus8_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus8_master.sv
// ibus8_master: initiator for the 8-bit internal peripheral bus.
// Sequences setup/strobe/hold around one request at a time.
module ibus8_master #(
  parameter int ADDR_W     = 8,
  parameter int CS_BITS    = 3,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [7:0]                wdata,
  output logic [7:0]                rdata,
  output logic                      ack,
  output logic                      busy,
  output logic [ADDR_W-CS_BITS-1:0] bus_addr,
  output logic [(2**CS_BITS)-1:0]   en,
  output logic [7:0]                data_o,
  input  logic [7:0]                data_i,
  output logic                      wr_n,
  output logic                      rd_n
);

  localparam int N_CS = 2**CS_BITS;
  localparam int BA_W = ADDR_W - CS_BITS;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  generate
    if (SETUP_CYC < 1 || SETUP_CYC > 255 ||
        STROBE_CYC < 1 || STROBE_CYC > 255 ||
        HOLD_CYC < 1 || HOLD_CYC > 255 ||
        CS_BITS < 1 || ADDR_W <= CS_BITS)
    begin : g_bad_param
      $error("ibus8_master: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [N_CS-1:0]   en_q, en_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    ba_d    = ba_q;
    en_d    = en_q;
    dout_d  = dout_q;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          we_d    = we;
          en_d    = N_CS'(1) << addr[ADDR_W-1 -: CS_BITS];
          ba_d    = addr[BA_W-1:0];
          dout_d  = we ? wdata : 8'h00;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          wr_n_d  = ~we_q;
          rd_n_d  = we_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          if (!we_q) rdata_d = data_i;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          ack_d   = 1'b1;
          en_d    = '0;
          ba_d    = '0;
          dout_d  = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset parks the bus idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ba_q    <= '0;
      en_q    <= '0;
      dout_q  <= 8'h00;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ba_q    <= ba_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign bus_addr = ba_q;
  assign en       = en_q;
  assign data_o   = dout_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;

endmodule

// File: tb/tb_ibus8_master.sv
// tb_ibus8_master: scoreboard bench for ibus8_master.
// Default instance plus a stretched-timing instance.
module tb_ibus8_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, req2, we;
  logic [7:0] addr, wdata, data_i;

  logic [7:0] rdata, data_o, en;
  logic [4:0] bus_addr;
  logic       ack, busy, wr_n, rd_n;

  logic [7:0] rdata2, data_o2, en2;
  logic [4:0] bus_addr2;
  logic       ack2, busy2, wr_n2, rd_n2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic [7:0] rdata_m;
  logic [7:0] periph [8];

  localparam logic [24:0] IDLE_BUS =
    {8'h00, 5'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  ibus8_master u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .ack(ack), .busy(busy), .bus_addr(bus_addr),
    .en(en), .data_o(data_o), .data_i(data_i),
    .wr_n(wr_n), .rd_n(rd_n)
  );

  ibus8_master #(
    .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3)
  ) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata2),
    .ack(ack2), .busy(busy2), .bus_addr(bus_addr2),
    .en(en2), .data_o(data_o2), .data_i(data_i),
    .wr_n(wr_n2), .rd_n(rd_n2)
  );

  // Peripheral model: registers latch on the rising write strobe.
  always @(posedge wr_n) begin
    for (int i = 0; i < 8; i++)
      if (en[i]) periph[i] = data_o;
  end

  function automatic logic [24:0] exp_bus(
    input int c, input int s, input int t, input int h,
    input logic w, input logic [7:0] e,
    input logic [4:0] b, input logic [7:0] d);
    logic act, stb, ackc;
    act  = (c >= 1) && (c <= s + t + h);
    stb  = (c >= s + 1) && (c <= s + t);
    ackc = (c == s + t + h + 1);
    return {act ? e : 8'h00, act ? b : 5'h00,
            (act && w) ? d : 8'h00,
            ~(stb && w), ~(stb && !w), ackc, act};
  endfunction

  function automatic logic [24:0] obs1();
    return {en, bus_addr, data_o, wr_n, rd_n, ack, busy};
  endfunction

  function automatic logic [24:0] obs2();
    return {en2, bus_addr2, data_o2, wr_n2, rd_n2, ack2, busy2};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0;
    addr = 8'h00; wdata = 8'h00; data_i = 8'h00;
    for (int i = 0; i < 8; i++) periph[i] = 8'h00;
    rdata_m = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (obs1() !== IDLE_BUS) begin
      n_fail++;
      $display("FAIL reset_bus got %h want %h", obs1(), IDLE_BUS);
    end
    n_assert++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata got %h want 00", rdata);
    end
    n_assert++;
    if (obs2() !== IDLE_BUS) begin
      n_fail++;
      $display("FAIL reset_bus2 got %h want %h", obs2(), IDLE_BUS);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [24:0] e;
    logic [7:0]  r;
    addr = 8'h00; wdata = 8'h05; we = 1'b1; req = 1'b1;
    sb.push_back(rdata_m);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      e = exp_bus(c, 1, 2, 1, 1'b1, 8'h01, 5'h00, 8'h05);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL write_c%0d got %h want %h", c, obs1(), e);
      end
      if (ack === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata !== r) begin
          n_fail++;
          $display("FAIL write_rdata got %h want %h", rdata, r);
        end
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL write_acks pending %0d want 0", sb.size());
    end
    sb.delete();
    n_assert++;
    if (periph[0] !== 8'h05) begin
      n_fail++;
      $display("FAIL write_periph got %h want 05", periph[0]);
    end
  endtask

  task automatic test_read();
    logic [24:0] e;
    logic [7:0]  r;
    addr = 8'h43; we = 1'b0; data_i = 8'hA5; req = 1'b1;
    rdata_m = 8'hA5;
    sb.push_back(rdata_m);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      e = exp_bus(c, 1, 2, 1, 1'b0, 8'h04, 5'h03, 8'h00);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL read_c%0d got %h want %h", c, obs1(), e);
      end
      if (ack === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata !== r) begin
          n_fail++;
          $display("FAIL read_rdata got %h want %h", rdata, r);
        end
      end
    end
    data_i = 8'h00;
    addr = 8'h00; wdata = 8'h11; we = 1'b1; req = 1'b1;
    sb.push_back(rdata_m);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      if (ack === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata !== r) begin
          n_fail++;
          $display("FAIL wr_keeps_rdata got %h want %h", rdata, r);
        end
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL read_acks pending %0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [24:0] e;
    logic [7:0]  r;
    addr = 8'h20; wdata = 8'h77; we = 1'b1; req = 1'b1;
    sb.push_back(rdata_m);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        we = 1'b0; addr = 8'hE1; data_i = 8'h3C;
        rdata_m = 8'h3C;
        sb.push_back(rdata_m);
      end
      if (c == 6) req = 1'b0;
      if (c <= 5)
        e = exp_bus(c, 1, 2, 1, 1'b1, 8'h02, 5'h00, 8'h77);
      else
        e = exp_bus(c - 5, 1, 2, 1, 1'b0, 8'h80, 5'h01, 8'h00);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL b2b_c%0d got %h want %h", c, obs1(), e);
      end
      if (ack === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata !== r) begin
          n_fail++;
          $display("FAIL b2b_rdata_c%0d got %h want %h", c, rdata, r);
        end
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_acks pending %0d want 0", sb.size());
    end
    sb.delete();
    n_assert++;
    if (periph[1] !== 8'h77) begin
      n_fail++;
      $display("FAIL b2b_periph got %h want 77", periph[1]);
    end
    data_i = 8'h00;
  endtask

  task automatic test_busy_ignore();
    logic [24:0] e;
    int acks;
    acks = 0;
    addr = 8'h00; wdata = 8'h22; we = 1'b1; req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      if (c == 2) begin
        req = 1'b1; addr = 8'h40; wdata = 8'h99;
      end
      if (c == 3) req = 1'b0;
      e = exp_bus(c, 1, 2, 1, 1'b1, 8'h01, 5'h00, 8'h22);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL busy_c%0d got %h want %h", c, obs1(), e);
      end
      if (ack === 1'b1) acks++;
    end
    n_assert++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL busy_acks got %0d want 1", acks);
    end
    n_assert++;
    if (periph[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL busy_periph2 got %h want 00", periph[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] e;
    logic [7:0]  r;
    addr = 8'h00; wdata = 8'h33; we = 1'b1; req = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      e = exp_bus(c, 1, 2, 1, 1'b1, 8'h01, 5'h00, 8'h33);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL rstmid_c%0d got %h want %h", c, obs1(), e);
      end
    end
    rst = 1'b1;
    rdata_m = 8'h00;
    #1;
    n_assert++;
    if (obs1() !== IDLE_BUS) begin
      n_fail++;
      $display("FAIL rstmid_async got %h want %h", obs1(), IDLE_BUS);
    end
    n_assert++;
    if (rdata !== rdata_m) begin
      n_fail++;
      $display("FAIL rstmid_rdata got %h want %h", rdata, rdata_m);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      n_assert++;
      if (obs1() !== IDLE_BUS) begin
        n_fail++;
        $display("FAIL rstmid_idle_c%0d got %h want %h",
                 c, obs1(), IDLE_BUS);
      end
    end
    addr = 8'h43; we = 1'b0; data_i = 8'h5A; req = 1'b1;
    rdata_m = 8'h5A;
    sb.push_back(rdata_m);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
      e = exp_bus(c, 1, 2, 1, 1'b0, 8'h04, 5'h03, 8'h00);
      n_assert++;
      if (obs1() !== e) begin
        n_fail++;
        $display("FAIL rstrd_c%0d got %h want %h", c, obs1(), e);
      end
      if (ack === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata !== r) begin
          n_fail++;
          $display("FAIL rstrd_rdata got %h want %h", rdata, r);
        end
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rstrd_acks pending %0d want 0", sb.size());
    end
    sb.delete();
    data_i = 8'h00;
  endtask

  task automatic test_timing();
    logic [24:0] e;
    logic [7:0]  r;
    addr = 8'h60; wdata = 8'h44; we = 1'b1; req2 = 1'b1;
    sb.push_back(8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) req2 = 1'b0;
      e = exp_bus(c, 2, 4, 3, 1'b1, 8'h08, 5'h00, 8'h44);
      n_assert++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL timing_c%0d got %h want %h", c, obs2(), e);
      end
      if (ack2 === 1'b1 && sb.size() > 0) begin
        r = sb.pop_front();
        n_assert++;
        if (rdata2 !== r) begin
          n_fail++;
          $display("FAIL timing_rdata got %h want %h", rdata2, r);
        end
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timing_acks pending %0d want 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
